// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported synchronous memory between an instruction-fetch
//   port (read only) and a load/store port. At most one memory command is in
//   flight. Arbitration happens only in IDLE. The winning command is issued
//   for exactly one cycle (ISSUE). A read then waits cRdLat cycles for its data
//   (RD_WAIT).
//
//   Request/grant handshake: a requester raises req with its payload and holds
//   both stable until it sees its gnt. gnt is high for the single ISSUE cycle
//   of its command. The payload is captured only on the IDLE cycle that
//   selects the requester. Dropping req before gnt withdraws the request with
//   no side effect. A read answers with one rvalid cycle exactly cRdLat cycles
//   after gnt. Rdata is iMemRdata passed through in that cycle and 0 at all
//   other times.
//
//   Optional build macro MEM_ARB_FAIRNESS_EN: adds a saturating starvation
//   counter. While fetch is waiting, the counter counts load/store grants.
//   When it reaches cStarveMax, fetch wins the next arbitration. Without the
//   macro, load/store has strict priority.
//
//   Ports
//     iClk, iRst                   clock, synchronous active-high reset
//     iIfReq/iIfAddr               fetch request and address
//     oIfGnt/oIfRvalid/oIfRdata    fetch grant, read response
//     iLsReq/iLsWe/iLsAddr/
//     iLsWdata/iLsBe               load/store request (iLsWe=1 means store)
//     oLsGnt/oLsRvalid/oLsRdata    load/store grant, read response
//     oMemEn/oMemWe/oMemAddr/
//     oMemWdata/oMemBe             memory command (valid while oMemEn=1)
//     iMemRdata                    memory read data
//     oBusy                        arbiter not in IDLE (FSM state visibility)
module mem_port_arbiter #(
  parameter int cAddrW     = 32,
  parameter int cDataW     = 32,
  parameter int cRdLat     = 2,
  parameter int cStarveMax = 4
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iIfReq,
  input  logic [cAddrW-1:0]   iIfAddr,
  output logic                oIfGnt,
  output logic                oIfRvalid,
  output logic [cDataW-1:0]   oIfRdata,
  input  logic                iLsReq,
  input  logic                iLsWe,
  input  logic [cAddrW-1:0]   iLsAddr,
  input  logic [cDataW-1:0]   iLsWdata,
  input  logic [cDataW/8-1:0] iLsBe,
  output logic                oLsGnt,
  output logic                oLsRvalid,
  output logic [cDataW-1:0]   oLsRdata,
  output logic                oMemEn,
  output logic                oMemWe,
  output logic [cAddrW-1:0]   oMemAddr,
  output logic [cDataW-1:0]   oMemWdata,
  output logic [cDataW/8-1:0] oMemBe,
  input  logic [cDataW-1:0]   iMemRdata,
  output logic                oBusy
);

  localparam int cBeW  = cDataW / 8;
  localparam int cCntW = $clog2(cRdLat + 1);

  if (cRdLat < 1 || cStarveMax < 1 || (cDataW % 8) != 0) begin : g_param_check
    $error("mem_port_arbiter: illegal parameter set");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  state_t             state;
  logic               owner_ls;   // 1: load/store owns the command, 0: fetch
  logic [cAddrW-1:0]  cmd_addr;
  logic               cmd_we;
  logic [cDataW-1:0]  cmd_wdata;
  logic [cBeW-1:0]    cmd_be;
  logic [cCntW-1:0]   lat_cnt;
  logic               mem_en_q;
  logic               mem_we_q;
  logic               if_gnt_q;
  logic               ls_gnt_q;
  logic               if_rvalid_q;
  logic               ls_rvalid_q;
  logic               fetch_forced;
  logic               pick_ls;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int cStarveW = $clog2(cStarveMax + 1);

  logic [cStarveW-1:0] starve_cnt;

  // Counted on the grant (ISSUE) cycle, so a fetch request that is withdrawn
  // while load/store is being served is not counted as starving.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      starve_cnt <= '0;
    end else if (state == ISSUE) begin
      if (!owner_ls) begin
        starve_cnt <= '0;
      end else if (iIfReq && (starve_cnt != cStarveW'(cStarveMax))) begin
        starve_cnt <= starve_cnt + cStarveW'(1);
      end
    end
  end

  assign fetch_forced = iIfReq && (starve_cnt == cStarveW'(cStarveMax));
`else
  assign fetch_forced = 1'b0;
`endif

  assign pick_ls = iLsReq && !fetch_forced;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state       <= IDLE;
      owner_ls    <= 1'b0;
      cmd_addr    <= '0;
      cmd_we      <= 1'b0;
      cmd_wdata   <= '0;
      cmd_be      <= '0;
      lat_cnt     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
    end else begin
      // Single-cycle strobes; each state below raises the ones it needs.
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (iIfReq || iLsReq) begin
            owner_ls <= pick_ls;
            if (pick_ls) begin
              cmd_addr  <= iLsAddr;
              cmd_we    <= iLsWe;
              cmd_wdata <= iLsWdata;
              cmd_be    <= iLsBe;
            end else begin
              cmd_addr  <= iIfAddr;
              cmd_we    <= 1'b0;
              cmd_wdata <= '0;
              cmd_be    <= '1;
            end
            // Strobes for the ISSUE cycle are set up one cycle early so
            // that they come straight from flops.
            mem_en_q <= 1'b1;
            mem_we_q <= pick_ls && iLsWe;
            ls_gnt_q <= pick_ls;
            if_gnt_q <= !pick_ls;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_we) begin
            state <= IDLE;
          end else begin
            lat_cnt <= cCntW'(cRdLat - 1);
            state   <= RD_WAIT;
            // With one-cycle latency the first RD_WAIT cycle is the response.
            if (cRdLat == 1) begin
              ls_rvalid_q <= owner_ls;
              if_rvalid_q <= !owner_ls;
            end
          end
        end
        RD_WAIT: begin
          if (lat_cnt == '0) begin
            state <= IDLE;
          end else begin
            lat_cnt <= lat_cnt - cCntW'(1);
            if (lat_cnt == cCntW'(1)) begin
              ls_rvalid_q <= owner_ls;
              if_rvalid_q <= !owner_ls;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign oMemEn    = mem_en_q;
  assign oMemWe    = mem_we_q;
  assign oMemAddr  = cmd_addr;
  assign oMemWdata = cmd_wdata;
  assign oMemBe    = cmd_be;
  assign oIfGnt    = if_gnt_q;
  assign oLsGnt    = ls_gnt_q;
  assign oIfRvalid = if_rvalid_q;
  assign oLsRvalid = ls_rvalid_q;
  // A reset clears the rvalid flags, so late memory data is never forwarded.
  assign oIfRdata  = if_rvalid_q ? iMemRdata : '0;
  assign oLsRdata  = ls_rvalid_q ? iMemRdata : '0;
  assign oBusy     = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic.
// The reference model works on a transaction timeline. When an arbitration
// happens, it computes the grant cycle, the response cycle and the cycle at
// which the arbiter is free again. It then compares every output against
// those times each cycle.
module tb_mem_port_arbiter;
  localparam int cAddrW     = 32;
  localparam int cDataW     = 32;
  localparam int cBeW       = cDataW / 8;
  localparam int cRdLat     = 2;
  localparam int cStarveMax = 4;
`ifdef MEM_ARB_FAIRNESS_EN
  localparam bit cFair = 1'b1;
`else
  localparam bit cFair = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              iClk = 1'b0;
  logic              iRst;
  logic              iIfReq;
  logic [cAddrW-1:0] iIfAddr;
  logic              oIfGnt, oIfRvalid;
  logic [cDataW-1:0] oIfRdata;
  logic              iLsReq, iLsWe;
  logic [cAddrW-1:0] iLsAddr;
  logic [cDataW-1:0] iLsWdata;
  logic [cBeW-1:0]   iLsBe;
  logic              oLsGnt, oLsRvalid;
  logic [cDataW-1:0] oLsRdata;
  logic              oMemEn, oMemWe;
  logic [cAddrW-1:0] oMemAddr;
  logic [cDataW-1:0] oMemWdata;
  logic [cBeW-1:0]   oMemBe;
  logic [cDataW-1:0] iMemRdata;
  logic              oBusy;

  always #5 iClk = ~iClk;

  mem_port_arbiter #(
    .cAddrW(cAddrW), .cDataW(cDataW), .cRdLat(cRdLat), .cStarveMax(cStarveMax)
  ) dut (
    .iClk(iClk), .iRst(iRst),
    .iIfReq(iIfReq), .iIfAddr(iIfAddr),
    .oIfGnt(oIfGnt), .oIfRvalid(oIfRvalid), .oIfRdata(oIfRdata),
    .iLsReq(iLsReq), .iLsWe(iLsWe), .iLsAddr(iLsAddr),
    .iLsWdata(iLsWdata), .iLsBe(iLsBe),
    .oLsGnt(oLsGnt), .oLsRvalid(oLsRvalid), .oLsRdata(oLsRdata),
    .oMemEn(oMemEn), .oMemWe(oMemWe), .oMemAddr(oMemAddr),
    .oMemWdata(oMemWdata), .oMemBe(oMemBe),
    .iMemRdata(iMemRdata), .oBusy(oBusy)
  );

  // ---------------- drive values, applied just after each rising edge ----------------
  logic              d_rst = 1'b1;
  logic              d_if_req = 1'b0;
  logic [cAddrW-1:0] d_if_addr = '0;
  logic              d_ls_req = 1'b0;
  logic              d_ls_we = 1'b0;
  logic [cAddrW-1:0] d_ls_addr = '0;
  logic [cDataW-1:0] d_ls_wdata = '0;
  logic [cBeW-1:0]   d_ls_be = '0;
  logic [cDataW-1:0] d_mem_rdata = '0;

  // ---------------- scoreboard / reference model ----------------
  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_on = 1'b0;
  int idle_from = 0;        // first cycle the arbiter is idle again
  int issue_cyc = -1;       // cycle of the pending command's grant
  int resp_cyc = -1;        // cycle of the pending read's response
  int starve = 0;
  bit own_ls = 1'b0;
  bit m_we = 1'b0;
  logic [cDataW-1:0] m_wdata = '0;
  logic [cBeW-1:0]   m_be = '0;
  logic [cAddrW-1:0] exp_q[$];  // expected command addresses, in grant order
  bit grant_log[$];             // 1 = fetch grant, 0 = load/store grant

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_cycle();
    bit is_issue;
    bit is_resp;
    logic [cAddrW-1:0] e_addr;
    is_issue = (cyc == issue_cyc);
    is_resp  = (cyc == resp_cyc);
    check("busy",      64'(oBusy),     64'(cyc < idle_from));
    check("mem_en",    64'(oMemEn),    64'(is_issue));
    check("mem_we",    64'(oMemWe),    64'(is_issue && m_we));
    check("if_gnt",    64'(oIfGnt),    64'(is_issue && !own_ls));
    check("ls_gnt",    64'(oLsGnt),    64'(is_issue && own_ls));
    check("if_rvalid", 64'(oIfRvalid), 64'(is_resp && !own_ls));
    check("ls_rvalid", 64'(oLsRvalid), 64'(is_resp && own_ls));
    check("if_rdata",  64'(oIfRdata),  (is_resp && !own_ls) ? 64'(d_mem_rdata) : 64'd0);
    check("ls_rdata",  64'(oLsRdata),  (is_resp && own_ls) ? 64'(d_mem_rdata) : 64'd0);
    if (is_issue) begin
      e_addr = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check("mem_addr", 64'(oMemAddr), 64'(e_addr));
      check("mem_be",   64'(oMemBe),   64'(m_be));
      if (own_ls && m_we) check("mem_wdata", 64'(oMemWdata), 64'(m_wdata));
    end
    if (oIfGnt || oLsGnt) grant_log.push_back(oIfGnt);
  endtask

  task automatic model_advance();
    bit fetch_wins;
    if (d_rst) begin
      idle_from = cyc + 1;
      issue_cyc = -1;
      resp_cyc  = -1;
      starve    = 0;
      exp_q.delete();
      return;
    end
    if (cyc == issue_cyc) begin
      if (!own_ls) starve = 0;
      else if (d_if_req && starve < cStarveMax) starve++;
    end
    if (cyc >= idle_from && (d_if_req || d_ls_req)) begin
      fetch_wins = !d_ls_req || (cFair && d_if_req && starve == cStarveMax);
      own_ls = !fetch_wins;
      if (own_ls) begin
        exp_q.push_back(d_ls_addr);
        m_we = d_ls_we; m_wdata = d_ls_wdata; m_be = d_ls_be;
      end else begin
        exp_q.push_back(d_if_addr);
        m_we = 1'b0; m_wdata = '0; m_be = '1;
      end
      issue_cyc = cyc + 1;
      if (m_we) begin
        resp_cyc  = -1;
        idle_from = cyc + 2;
      end else begin
        resp_cyc  = cyc + 1 + cRdLat;
        idle_from = cyc + 2 + cRdLat;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(posedge iClk);
    #1;
    iRst = d_rst; iIfReq = d_if_req; iIfAddr = d_if_addr;
    iLsReq = d_ls_req; iLsWe = d_ls_we; iLsAddr = d_ls_addr;
    iLsWdata = d_ls_wdata; iLsBe = d_ls_be; iMemRdata = d_mem_rdata;
    @(negedge iClk);
    if (chk_on) check_cycle();
    model_advance();
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit if_hold;
    bit ls_hold;
    int n;
    iRst = 1'b1; iIfReq = 1'b0; iIfAddr = '0; iLsReq = 1'b0; iLsWe = 1'b0;
    iLsAddr = '0; iLsWdata = '0; iLsBe = '0; iMemRdata = '0;

    // Reset: outputs are undefined before the first edge, so check only after it.
    d_rst = 1'b1;
    steps(2);
    chk_on = 1'b1;
    step();
    d_rst = 1'b0;
    step();

    // Single fetch read: grant one cycle after the request, data cRdLat later.
    d_if_req = 1'b1; d_if_addr = 32'h100; d_mem_rdata = 32'hDEADBEEF;
    step();
    step();
    check("fetch_issue_addr", 64'(oMemAddr), 64'h100);
    check("fetch_issue_gnt",  64'(oIfGnt),   64'd1);
    d_if_req = 1'b0;
    steps(2);
    check("fetch_rdata", 64'(oIfRdata), 64'hDEADBEEF);
    step();

    // Store: one ISSUE cycle, no response.
    d_ls_req = 1'b1; d_ls_we = 1'b1; d_ls_addr = 32'h20;
    d_ls_wdata = 32'h12345678; d_ls_be = 4'h3;
    step();
    step();
    check("store_we", 64'(oMemWe), 64'd1);
    check("store_be", 64'(oMemBe), 64'h3);
    d_ls_req = 1'b0;
    step();
    check("store_idle", 64'(oBusy), 64'd0);
    check("store_no_rvalid", 64'(oLsRvalid), 64'd0);

    // Simultaneous load and fetch: load first, fetch at the next IDLE.
    d_ls_req = 1'b1; d_ls_we = 1'b0; d_ls_addr = 32'h44; d_ls_be = 4'hF;
    d_if_req = 1'b1; d_if_addr = 32'h200; d_mem_rdata = 32'hCAFE0001;
    step();
    step();
    check("sim_ls_first", 64'(oLsGnt), 64'd1);
    d_ls_req = 1'b0;
    steps(2);
    check("sim_ls_rvalid", 64'(oLsRvalid), 64'd1);
    step();
    step();
    check("sim_if_second", 64'(oIfGnt), 64'd1);
    d_if_req = 1'b0;
    steps(3);

    // Both held continuously (stores keep it short): fairness pattern.
    grant_log.delete();
    d_ls_req = 1'b1; d_ls_we = 1'b1; d_ls_addr = 32'h80; d_ls_wdata = 32'h5A5A5A5A;
    d_if_req = 1'b1; d_if_addr = 32'h300;
    steps(24);
    d_ls_req = 1'b0; d_if_req = 1'b0;
    steps(2);
    check("fair_grant_count_ge10", 64'(grant_log.size() >= 10), 64'd1);
    n = (grant_log.size() < 10) ? grant_log.size() : 10;
    for (int k = 0; k < n; k++)
      check($sformatf("fair_grant_%0d", k), 64'(grant_log[k]), 64'(cFair && (k % 5 == 4)));

    // Reset one cycle after a load ISSUE aborts the read.
    d_ls_req = 1'b1; d_ls_we = 1'b0; d_ls_addr = 32'h90;
    step();
    step();
    check("abort_ls_gnt", 64'(oLsGnt), 64'd1);
    d_ls_req = 1'b0; d_rst = 1'b1;
    step();
    d_rst = 1'b0;
    step();
    check("abort_busy", 64'(oBusy), 64'd0);
    check("abort_no_rvalid", 64'(oLsRvalid), 64'd0);
    steps(2);

    // Random traffic: each requester holds until its grant, and sometimes
    // withdraws while it is not being granted.
    if_hold = 1'b0; ls_hold = 1'b0;
    for (int t = 0; t < 800; t++) begin
      if (!if_hold) begin
        if ($urandom_range(0, 2) == 0) begin
          d_if_req = 1'b1; d_if_addr = $urandom; if_hold = 1'b1;
        end else d_if_req = 1'b0;
      end else if ($urandom_range(0, 15) == 0 && !(issue_cyc == cyc && !own_ls)) begin
        d_if_req = 1'b0; if_hold = 1'b0;
      end
      if (!ls_hold) begin
        if ($urandom_range(0, 1) == 0) begin
          d_ls_req = 1'b1; d_ls_we = 1'($urandom_range(0, 1)); d_ls_addr = $urandom;
          d_ls_wdata = $urandom; d_ls_be = 4'($urandom_range(0, 15)); ls_hold = 1'b1;
        end else d_ls_req = 1'b0;
      end else if ($urandom_range(0, 15) == 0 && !(issue_cyc == cyc && own_ls)) begin
        d_ls_req = 1'b0; ls_hold = 1'b0;
      end
      d_mem_rdata = $urandom;
      d_rst = ($urandom_range(0, 99) == 0);
      step();
      if (oIfGnt) if_hold = 1'b0;
      if (oLsGnt) ls_hold = 1'b0;
    end
    d_rst = 1'b0; d_if_req = 1'b0; d_ls_req = 1'b0;
    steps(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
